// File: rtl/router_fifo.sv
// Per-port packet-aware output FIFO: stores {hdr flag, byte}, flags the parity byte on pkt_end; read data 1 cycle after read_enb.
// Writes while full are dropped, reads while empty are ignored; soft_reset flushes all pointers/counters with priority.
module router_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             soft_reset,
  input  logic             write_enb,
  input  logic             lfd_state,
  input  logic [WIDTH-1:0] data_in,
  input  logic             read_enb,
  output logic [WIDTH-1:0] data_out,
  output logic             pkt_end,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH:0]   mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [6:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             pkt_end_q, pkt_end_d;
  logic [WIDTH:0]   rd_entry;
  logic             wr_acc, rd_acc;

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign wr_acc   = write_enb && !full && !soft_reset;
  assign rd_acc   = read_enb && !empty && !soft_reset;
  assign rd_entry = mem_q[rd_ptr_q[AW-1:0]];
  assign data_out = data_out_q;
  assign pkt_end  = pkt_end_q;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    data_out_d = data_out_q;
    pkt_end_d  = 1'b0;
    if (soft_reset) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      cnt_d      = '0;
      data_out_d = '0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      if (rd_acc) begin
        rd_ptr_d   = rd_ptr_q + (AW+1)'(1);
        data_out_d = rd_entry[WIDTH-1:0];
        // Header reload always wins, so a truncated packet never raises pkt_end.
        if (rd_entry[WIDTH]) begin
          cnt_d = {1'b0, rd_entry[7:2]} + 7'd1;
        end else if (cnt_q != 7'd0) begin
          cnt_d     = cnt_q - 7'd1;
          pkt_end_d = (cnt_q == 7'd1);
        end
      end
    end
  end

  // Storage has no reset; flushed entries are simply unreachable.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q[AW-1:0]] <= {lfd_state, data_in};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      data_out_q <= '0;
      pkt_end_q  <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      data_out_q <= data_out_d;
      pkt_end_q  <= pkt_end_d;
    end
  end

endmodule
